// File: rtl/umi_fifo_sync.sv
// Single-clock UMI packet FIFO with occupancy count, almost-full flag and LFSR chaos pushback.
// Latency: a packet written in cycle N is visible at the output in cycle N+1; bypass is zero-cycle.
// Backpressure: umi_in_ready drops when full or when chaos blocks; a read never reopens a full FIFO in the same cycle.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   bypass               1: combinational pass-through, FIFO state frozen
//   chaosmode            1: pseudo-random input pushback from a 16-bit LFSR
//   fifo_full/afull/empty/count   status derived from the registered occupancy
//   umi_in_*             input packet channel (valid/ready)
//   umi_out_*            output packet channel (valid/ready), first-word fall-through
module umi_fifo_sync #(
    parameter int          DW    = 256,
    parameter int          DEPTH = 4,
    parameter int          AFULL = 3,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bypass,
    input  logic                       chaosmode,
    output logic                       fifo_full,
    output logic                       fifo_afull,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH):0]     fifo_count,
    input  logic                       umi_in_valid,
    input  logic [DW-1:0]              umi_in_packet,
    output logic                       umi_in_ready,
    output logic                       umi_out_valid,
    output logic [DW-1:0]              umi_out_packet,
    input  logic                       umi_out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Storage and state
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_lfsr;

    // Derived wires
    logic          w_full;
    logic          w_afull;
    logic          w_empty;
    logic          w_chaos_block;
    logic          w_lfsr_fb;
    logic [15:0]   w_lfsr_next;
    logic          w_wr;
    logic          w_rd;

    // Flags come from the registered count only, so no combinational path
    // runs from umi_out_ready to umi_in_ready.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_afull = (r_count >= CW'(AFULL));
    assign w_empty = (r_count == '0);

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    assign w_lfsr_fb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_lfsr_next   = {w_lfsr_fb, r_lfsr[15:1]};
    assign w_chaos_block = chaosmode & r_lfsr[0];

    // Status outputs are forced to their reset values while reset is high so
    // they are defined even before the first reset edge has been sampled.
    assign fifo_full  = ~reset & w_full;
    assign fifo_afull = ~reset & w_afull;
    assign fifo_empty = reset | w_empty;
    assign fifo_count = reset ? '0 : r_count;

    always_comb begin
        umi_out_valid  = 1'b0;
        umi_out_packet = r_mem[r_rd_ptr];
        umi_in_ready   = 1'b0;
        if (bypass) begin
            umi_out_valid  = umi_in_valid & ~reset;
            umi_out_packet = umi_in_packet;
            umi_in_ready   = umi_out_ready;
        end else begin
            umi_out_valid  = ~fifo_empty;
            umi_out_packet = r_mem[r_rd_ptr];
            umi_in_ready   = ~fifo_full & ~w_chaos_block;
        end
    end

    // Bypass freezes the FIFO: no pushes, no pops.
    assign w_wr = ~bypass & umi_in_valid & umi_in_ready;
    assign w_rd = ~bypass & umi_out_valid & umi_out_ready;

    // Pointers, occupancy and LFSR
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_lfsr   <= SEED;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_wr) - CW'(w_rd);
            if (chaosmode & ~bypass) begin
                r_lfsr <= w_lfsr_next;
            end
        end
    end

    // Packet storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_wr & ~reset) begin
            r_mem[r_wr_ptr] <= umi_in_packet;
        end
    end

    // Occupancy must stay within the array size.
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        r_count <= CW'(DEPTH));

endmodule
